// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the three-master bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [1:0] M_CPU    = 2'd0;
    localparam logic [1:0] M_DMA    = 2'd1;
    localparam logic [1:0] M_GPU    = 2'd2;
    localparam logic [1:0] NO_OWNER = 2'b11;

    // Successor of a master index in the CPU -> DMA -> GPU ring.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= M_GPU) ? M_CPU : idx + 2'd1;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        return (idx == NO_OWNER) ? 3'b000 : (3'b001 << idx);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner select: search starts just after last.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] cand [3];
    logic [2:0] hit;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
        if (gi == 0) begin : g_first
            assign cand[gi] = next_idx(last);
        end else begin : g_rest
            assign cand[gi] = next_idx(cand[gi-1]);
        end
        assign hit[gi] = req[cand[gi]];
    end

    always_comb begin
        valid  = 1'b0;
        winner = NO_OWNER;
        if (hit[0]) begin
            valid  = 1'b1;
            winner = cand[0];
        end else if (hit[1]) begin
            valid  = 1'b1;
            winner = cand[1];
        end else if (hit[2]) begin
            valid  = 1'b1;
            winner = cand[2];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master bus arbiter: round-robin grants, hold-time preemption,
// dead-bus turnaround between owners and a locked-overrun pulse.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] turn_q, turn_d;
    logic       err_q, err_d;
    logic       err_done_q, err_done_d;

    logic       pick_valid;
    logic [1:0] pick_winner;
    logic       own_req, own_lock, others_wait;

    rr_pick u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Masking with the one-hot grant avoids indexing by an encoded owner.
    assign own_req     = |(req & gnt_q);
    assign own_lock    = |(lock & gnt_q);
    assign others_wait = |(req & ~gnt_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        err_d      = 1'b0;
        err_done_d = err_done_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = 3'b000;
                if (pick_valid) begin
                    gnt_d      = onehot3(pick_winner);
                    last_d     = pick_winner;
                    hold_d     = 8'd0;
                    err_done_d = 1'b0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
                if (!own_req) begin
                    gnt_d   = 3'b000;
                    turn_d  = 2'd0;
                    state_d = ST_TURN;
                end else if (hold_q == HOLD_MAX && others_wait) begin
                    if (!own_lock) begin
                        gnt_d   = 3'b000;
                        turn_d  = 2'd0;
                        state_d = ST_TURN;
                    end else if (!err_done_q) begin
                        err_d      = 1'b1;
                        err_done_d = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                gnt_d = 3'b000;
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                    if (pick_valid) begin
                        gnt_d      = onehot3(pick_winner);
                        last_d     = pick_winner;
                        hold_d     = 8'd0;
                        err_done_d = 1'b0;
                        state_d    = ST_GRANT;
                    end
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            last_q     <= M_GPU;
            hold_q     <= 8'd0;
            turn_q     <= 2'd0;
            err_q      <= 1'b0;
            err_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            err_q      <= err_d;
            err_done_q <= err_done_d;
        end
    end

    always_comb begin
        case (gnt_q)
            3'b001:  owner = M_CPU;
            3'b010:  owner = M_DMA;
            3'b100:  owner = M_GPU;
            default: owner = NO_OWNER;
        endcase
    end

    assign busy        = |gnt_q;
    assign gnt         = gnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: per-cycle expected grant/error queued at drive time.
module tb_bus_arbiter;

    localparam int MH = 16;
    localparam int TC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] gnt;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    bus_arbiter #(.MAX_HOLD(MH), .TURN_CYCLES(TC)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [1:0] exp_owner(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'b11;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rst, input logic [2:0] r, input logic [2:0] l,
                        input logic [2:0] eg, input logic ee, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        lock  = l;
        e.gnt = eg;
        e.err = ee;
        e.tag = tag;
        sb.push_back(e);
        $display("drive %-14s rst=%b req=%b lock=%b -> exp gnt=%b err=%b", tag, rst, r, l, eg, ee);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".gnt"},   32'(gnt),         32'(e.gnt));
            chk({e.tag, ".owner"}, 32'(owner),       32'(exp_owner(e.gnt)));
            chk({e.tag, ".busy"},  32'(busy),        32'(|e.gnt));
            chk({e.tag, ".err"},   32'(timeout_err), 32'(e.err));
        end
    end

    // Invariant monitor: one-hot-or-zero grant, and a dead-bus gap on every owner change.
    logic [2:0] prev_gnt = 3'b000;
    int         zero_run = 0;
    always @(posedge clk) begin : inv_monitor
        #1;
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (reset) begin
            prev_gnt = 3'b000;
            zero_run = 0;
        end else if (gnt == 3'b000) begin
            zero_run++;
        end else begin
            if (prev_gnt != 3'b000 && gnt != prev_gnt)
                chk("turn_gap", 32'(zero_run >= TC), 32'd1);
            prev_gnt = gnt;
            zero_run = 0;
        end
    end

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;

        // Reset with requests present: they must be ignored.
        step(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, "rst");
        step(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, "rst");

        // All three requesting: round-robin rotation with 16-cycle preemption.
        for (int i = 0; i < 16; i++) step(1'b0, 3'b111, 3'b000, 3'b001, 1'b0, "rr_cpu");
        step(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, "rr_turn0");
        for (int i = 0; i < 16; i++) step(1'b0, 3'b111, 3'b000, 3'b010, 1'b0, "rr_dma");
        step(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, "rr_turn1");
        for (int i = 0; i < 16; i++) step(1'b0, 3'b111, 3'b000, 3'b100, 1'b0, "rr_gpu");
        step(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, "rr_turn2");
        step(1'b0, 3'b111, 3'b000, 3'b001, 1'b0, "rr_wrap");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "rr_drop");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "rr_idle");

        // Short DMA pulse.
        for (int i = 0; i < 5; i++) step(1'b0, 3'b010, 3'b000, 3'b010, 1'b0, "dma_pulse");
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "dma_end");

        // Locked CPU overruns while GPU waits: one timeout pulse, no preemption.
        step(1'b0, 3'b001, 3'b001, 3'b001, 1'b0, "lock_cpu");
        for (int i = 0; i < 15; i++) step(1'b0, 3'b101, 3'b001, 3'b001, 1'b0, "lock_hold");
        step(1'b0, 3'b101, 3'b001, 3'b001, 1'b1, "lock_timeout");
        for (int i = 0; i < 5; i++) step(1'b0, 3'b101, 3'b001, 3'b001, 1'b0, "lock_silent");
        step(1'b0, 3'b100, 3'b000, 3'b000, 1'b0, "lock_release");
        step(1'b0, 3'b100, 3'b000, 3'b100, 1'b0, "gpu_after");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "gpu_drop");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "gpu_idle");

        // Lone CPU: hold expiry with nobody waiting keeps the grant.
        for (int i = 0; i < 40; i++) step(1'b0, 3'b001, 3'b000, 3'b001, 1'b0, "lone_cpu");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "lone_drop");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "lone_idle");

        // Locked owner drops its request exactly at hold expiry: release, no pulse.
        step(1'b0, 3'b001, 3'b001, 3'b001, 1'b0, "sim_cpu");
        for (int i = 0; i < 15; i++) step(1'b0, 3'b101, 3'b001, 3'b001, 1'b0, "sim_hold");
        step(1'b0, 3'b100, 3'b001, 3'b000, 1'b0, "sim_drop");
        step(1'b0, 3'b100, 3'b000, 3'b100, 1'b0, "sim_gpu");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "sim_end");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "sim_idle");

        // Reset during a DMA grant, then DMA wins first afterwards.
        for (int i = 0; i < 4; i++) step(1'b0, 3'b010, 3'b000, 3'b010, 1'b0, "dma_grant");
        step(1'b1, 3'b010, 3'b000, 3'b000, 1'b0, "rst_mid");
        step(1'b0, 3'b110, 3'b000, 3'b010, 1'b0, "post_rst_dma");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "post_drop");
        step(1'b0, 3'b000, 3'b000, 3'b000, 1'b0, "post_idle");

        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum grant cycles before a preemptible owner is preempted while others wait (range 2..255).
REQ-002 Parameter TURN_CYCLES, default 1, is the number of dead-bus cycles between grants (range 1..3).
REQ-003 Port clk, input, 1, is the single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous, active-high reset.
REQ-005 Port req, input, 3, is the per-master bus request: bit0 CPU, bit1 DMA, bit2 GPU.
REQ-006 Port lock, input, 3, per master: the owner is not preemptible while its bit is set.
REQ-007 Port gnt, output, 3, is the registered one-hot grant; all-zero when the bus is unowned.
REQ-008 Port owner, output, 2, is the encoded current owner; 2'b11 when none.
REQ-009 Port busy, output, 1, is high whenever gnt is nonzero.
REQ-010 Port timeout_err, output, 1, is a one-cycle pulse on a locked overrun (REQ-021).

Function
REQ-011 States SHALL be IDLE, GRANT and TURN, encoded as an enum.
REQ-012 In IDLE with req==0: stay in IDLE, gnt=0.
REQ-013 In IDLE with req!=0: select a winner round-robin, starting at (last+1) mod 3 and skipping non-requesters; next edge gnt=onehot(winner), state=GRANT, last=winner, hold_cnt=0.
REQ-014 Request-to-grant latency SHALL be exactly 1 cycle from an idle bus.
REQ-015 In GRANT, hold_cnt increments each cycle and saturates at MAX_HOLD-1.
REQ-016 In GRANT, if req[owner]==0: next edge gnt=0, state=TURN.
REQ-017 In GRANT, if hold_cnt==MAX_HOLD-1, lock[owner]==0 and any other req bit is set: next edge gnt=0, state=TURN (preemption).
REQ-018 In GRANT, if hold_cnt==MAX_HOLD-1 and no other requester is waiting: the grant is kept, with no preemption.
REQ-019 TURN SHALL last exactly TURN_CYCLES cycles with gnt=0, then arbitrate as in IDLE on its final cycle; a pending req gets its grant on the next edge, giving back-to-back handover gap = TURN_CYCLES.
REQ-020 Changes to req during TURN SHALL NOT extend TURN; the arbitration in REQ-019 samples req on TURN's final cycle.
REQ-021 In GRANT, if lock[owner]==1, hold_cnt==MAX_HOLD-1 and another master is waiting: pulse timeout_err once, then stay silent until the grant ends.
REQ-022 The round-robin pointer last SHALL update only on grant.
REQ-023 gnt SHALL never have more than one bit set, and SHALL never go between two masters without passing through TURN.
REQ-024 owner and busy SHALL be derived combinationally from the registered gnt.
REQ-025 Simultaneous drop of req[owner] and hold expiry SHALL take the REQ-016 path, with no timeout_err.

Reset
REQ-026 On reset=1 at a clock edge: gnt=0, owner=2'b11, busy=0, timeout_err=0, state=IDLE, hold_cnt=0, last=2 (so the CPU wins first).
REQ-027 Reset mid-GRANT or mid-TURN SHALL drop gnt at that same edge, with no TURN cycle.
REQ-028 req sampled during the reset cycle SHALL be ignored.

Structure
REQ-029 Package bus_arbiter_pkg SHALL hold the state enum, master indices M_CPU=0, M_DMA=1, M_GPU=2, and NO_OWNER=2'b11.
REQ-030 One sub-module, rr_pick, SHALL be used: purely combinational, with inputs req[2:0] and last[1:0] and outputs valid and winner[1:0].
REQ-031 All outputs except owner and busy SHALL be registered; there is no combinational path from req to gnt.

Verification
REQ-032 Reset, then req=3'b111 held -> gnt=001 one cycle later, then 000 for 1 cycle, then 010, then 000, then 100 (MAX_HOLD=16, each grant lasting 16 cycles).
REQ-033 Only req[1] pulsed for 5 cycles -> gnt=010 from cycle 1 through cycle 5, then TURN, then IDLE; timeout_err stays 0.
REQ-034 CPU granted with lock[0]=1 and req[2] waiting -> grant held past 16 cycles, timeout_err high exactly 1 cycle at hold_cnt=15; GPU is granted TURN_CYCLES cycles after CPU drops req.
REQ-035 Lone CPU request held for 40 cycles -> gnt=001 continuously, with no preemption.
REQ-036 reset asserted during a DMA grant -> gnt=000 at that edge; after reset, req=3'b110 -> DMA is granted first (last=2).
REQ-037 An assertion checks that gnt is one-hot-or-zero every cycle and that a 000 gap of at least TURN_CYCLES separates every owner change.
